// File: rtl/mmu_pkg.sv
// ---------------------------------------------------------------------------
// mmu_pkg
// Shared definitions for the memory-sharing logic between the CPU and the
// program loader / DMA port.
//   MEM_REGION    : value of cpu_addr[15:13] that selects the on-chip memory
//   DEF_ADDR_W    : default memory word-address width (8K words)
//   DEF_DATA_W    : default data width
//   owner_t       : which master a pending read belongs to
// ---------------------------------------------------------------------------
package mmu_pkg;

  localparam logic [2:0] MEM_REGION = 3'b000;
  localparam int         DEF_ADDR_W = 13;
  localparam int         DEF_DATA_W = 32;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_t;

endpackage

// File: rtl/streak_counter.sv
// ---------------------------------------------------------------------------
// streak_counter
// Saturating fairness counter. Counts consecutive CPU grants taken while the
// loader is waiting, so the arbiter can force a loader turn once the limit
// is reached.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   i_clear     : return the count to zero (has priority over i_inc)
//   i_inc       : count one more CPU grant; holds once the limit is reached
//   o_atLimit   : count equals MAX_COUNT
// ---------------------------------------------------------------------------
module streak_counter #(
  parameter int MAX_COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_atLimit
);

  localparam logic [3:0] LIMIT = 4'(MAX_COUNT);

  logic [3:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
    end else if (i_clear) begin
      r_count <= 4'd0;
    end else if (i_inc && (r_count != LIMIT)) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign o_atLimit = (r_count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port 8Kx32 program/data memory between the CPU and the
// program loader / DMA port. One access is granted per cycle; the losing CPU
// is stalled, read data (one-cycle latency macro) is routed back to whoever
// issued the read. A fairness counter bounds how long the CPU can starve a
// waiting loader, and ld_excl hands the memory to the loader outright.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   cpu_req/addr/wdata/wren          : CPU access (addr[15:13]==0 is memory)
//   cpu_stall                        : CPU must hold its request (comb.)
//   cpu_rdata/cpu_rvalid             : CPU read return
//   ld_req/addr/wdata/wren, ld_excl  : loader access and exclusive mode
//   ld_gnt                           : loader access accepted (comb.)
//   ld_rdata/ld_rvalid               : loader read return
//   mem_addr/mem_wdata/mem_wren      : memory macro port
//   mem_q                            : memory read data, one cycle after addr
// ---------------------------------------------------------------------------
module mem_arbiter
  import mmu_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [15:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wren,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_wren,
  input  logic              ld_excl,
  output logic              ld_gnt,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  logic              w_cpuMem;
  logic              w_cpuWon;
  logic              w_ldWon;
  logic              w_grant;
  logic              w_atLimit;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selWdata;
  logic              w_selWren;
  logic              w_rdGrant;

  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic              r_rdPend;
  owner_t            r_owner;

  // Accesses outside the memory region are decoded elsewhere and never
  // compete for the memory.
  assign w_cpuMem = cpu_req && (cpu_addr[15:13] == MEM_REGION);

  // Priority: exclusive mode, then forced loader turn at the streak limit,
  // then the CPU, then the loader on an otherwise idle memory.
  always_comb begin
    w_cpuWon = 1'b0;
    w_ldWon  = 1'b0;
    if (ld_excl) begin
      w_ldWon = ld_req;
    end else if (ld_req && w_atLimit) begin
      w_ldWon = 1'b1;
    end else if (w_cpuMem) begin
      w_cpuWon = 1'b1;
    end else if (ld_req) begin
      w_ldWon = 1'b1;
    end
  end

  assign w_grant   = w_cpuWon || w_ldWon;
  assign cpu_stall = w_cpuMem && !w_cpuWon;
  assign ld_gnt    = w_ldWon;

  assign w_selAddr  = w_ldWon ? ld_addr  : cpu_addr[ADDR_W-1:0];
  assign w_selWdata = w_ldWon ? ld_wdata : cpu_wdata;
  assign w_selWren  = w_ldWon ? ld_wren  : cpu_wren;
  assign w_rdGrant  = w_grant && !w_selWren;

  // The streak only matters while the loader is actually waiting, so it is
  // dropped whenever the loader is quiet or gets its turn.
  streak_counter #(
    .MAX_COUNT (MAX_CPU_STREAK)
  ) u_streak (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_ldWon || !ld_req),
    .i_inc     (w_cpuWon && ld_req),
    .o_atLimit (w_atLimit)
  );

  // Holding registers keep the memory address/data stable on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else if (w_grant) begin
      r_memAddr  <= w_selAddr;
      r_memWdata <= w_selWdata;
    end
  end

  assign mem_addr  = w_grant ? w_selAddr  : r_memAddr;
  assign mem_wdata = w_grant ? w_selWdata : r_memWdata;
  // Writes are blocked outright while reset is held.
  assign mem_wren  = w_grant && w_selWren && !rst;

  // Owner is tracked per granted read so back-to-back reads from different
  // masters return without bubbles or cross-routing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPend <= 1'b0;
      r_owner  <= OWN_CPU;
    end else begin
      r_rdPend <= w_rdGrant;
      if (w_rdGrant) begin
        r_owner <= w_ldWon ? OWN_LD : OWN_CPU;
      end
    end
  end

  assign cpu_rvalid = r_rdPend && (r_owner == OWN_CPU);
  assign ld_rvalid  = r_rdPend && (r_owner == OWN_LD);
  assign cpu_rdata  = mem_q;
  assign ld_rdata   = mem_q;

endmodule
